sram_ctrl: RTL

- Parametrised successor to the 4-word x 8-bit flip-flop SRAM.
- Single-port, flop-based storage array with a registered read path.
- Adds a valid/ready request handshake and a sequenced wipe engine that zeroes the array one word per cycle, without asserting the global reset.
- Sits between a bus-side master and the storage array. Replaces the select/read-mode decoder and multiplexer scheme.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_ctrl_if.sv | 26 ++
 rtl/sram_array.sv | 82 ++++++++
 rtl/sram_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and helpers for sram_ctrl (parity option: SRAM_CTRL_PARITY_EN)
package sram_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WIPE = 1'b1
    } state_e;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W = 64;

    // Number of words addressed by an addr_w-bit address.
    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Even parity bit: makes the XOR of data and parity come out 0.
    function automatic logic parity_f(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - request/response bus between a master and sram_ctrl
interface sram_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              req;
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wipe;
    logic              ready;
    logic              busy;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic              par_err;

    modport master (
        output req, read, addr, wdata, wipe,
        input  ready, busy, rdata, rd_valid, par_err
    );

    modport slave (
        input  req, read, addr, wdata, wipe,
        output ready, busy, rdata, rd_valid, par_err
    );
endinterface

// File: rtl/sram_array.sv
// rtl/sram_array.sv - flop storage array, one write port, one registered read port (parity option: SRAM_CTRL_PARITY_EN)
module sram_array
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rd_valid_o,
    output logic              par_err_o
);
    localparam int DEPTH = depth_f(ADDR_W);
`ifdef SRAM_CTRL_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] wword;
    logic [WORD_W-1:0] rword;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_valid_q;

`ifdef SRAM_CTRL_PARITY_EN
    logic par_err_q;
    // Parity sits above the data bits; a zero word carries parity 0.
    assign wword = {parity_f(PAR_MAX_W'(wdata_i)), wdata_i};
`else
    assign wword = wdata_i;
`endif

    assign rword = mem_q[raddr_i];

    // Storage: clear zeroes every word, otherwise one word written per cycle.
    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wword;
        end
    end

    // Read port: data registered, held while no read is issued.
    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= re_i;
            if (re_i) begin
                rdata_q <= rword[DATA_W-1:0];
            end
        end
    end

`ifdef SRAM_CTRL_PARITY_EN
    // Parity check travels with rd_valid and is 0 when no read returns.
    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= re_i & (^rword);
        end
    end
    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

    assign rdata_o    = rdata_q;
    assign rd_valid_o = rd_valid_q;
endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - SRAM controller: valid/ready requests plus sequenced wipe (parity option: SRAM_CTRL_PARITY_EN)
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic       clk_i,
    input  logic       clear_i,
    sram_ctrl_if.slave bus
);
    localparam int DEPTH = depth_f(ADDR_W);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              wiping;
    logic              accept;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata_mux;

    assign wiping    = (state_q == ST_WIPE);
    assign bus.busy  = wiping;
    assign bus.ready = !wiping;

    // A request arriving with a wipe pulse is still accepted: ready is
    // computed from the current state, and the wipe only starts at this edge.
    assign accept = bus.req && !wiping;

    // The wipe engine shares the single write port, writing zeros at ptr.
    assign we        = (accept && !bus.read) || wiping;
    assign waddr     = wiping ? ptr_q : bus.addr;
    assign wdata_mux = wiping ? '0 : bus.wdata;

    // FSM state and wipe pointer registers.
    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: wipe walks ptr 0..DEPTH-1, one word per cycle, then idles.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wipe) begin
                    state_d = ST_WIPE;
                    ptr_d   = '0;
                end
            end
            ST_WIPE: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i      (clk_i),
        .clear_i    (clear_i),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata_mux),
        .re_i       (accept && bus.read),
        .raddr_i    (bus.addr),
        .rdata_o    (bus.rdata),
        .rd_valid_o (bus.rd_valid),
        .par_err_o  (bus.par_err)
    );
endmodule
